inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch initiator for the TinyMIPS core. It is the requester side of the instruction-ROM bus.
//  - Owns the PC and drives rom_en/rom_addr. Never writes.
//  - The ROM answers combinationally in the same cycle. The block registers {pc, inst} into the IF/ID stage.
//  - Handles pipeline stall, branch redirect (with MIPS delay slot) and exception flush.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000  first fetch address after reset
//  CNT_WIDTH  32             width of the fetch_count performance counter
// PORTS
//  clk            in   1   core clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hold PC and IF/ID outputs
//  flush          in   1   exception/eret flush; redirect to exc_pc
//  exc_pc         in   32  flush target
//  branch_flag    in   1   taken branch/jump resolved in ID
//  branch_target  in   32  branch destination
//  rom_en         out  1   ROM read enable
//  rom_write_en   out  4   byte write strobes; constant 4'b0000
//  rom_addr       out  32  fetch address (= pc_reg)
//  rom_write_data out  32  constant 0
//  rom_read_data  in   32  instruction word, valid in the same cycle as rom_addr
//  pc_out         out  32  PC of inst_out
//  inst_out       out  32  fetched instruction to ID
//  inst_valid     out  1   inst_out is a real instruction; when 0, ID treats it as a NOP
//  fetch_count    out  CNT_WIDTH  number of instructions delivered, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset values:
//  - pc_reg=RESET_PC, pc_out=0, inst_out=0, inst_valid=0, fetch_count=0, rom_en=0, state=BOOT.
//  - Reset asserted mid-operation discards everything at the next edge.
//  FSM:
//  - BOOT: exactly one cycle after rst deasserts; rom_en=0; then goes to RUN.
//  - RUN: rom_en = ~stall.
//  Fetch latency:
//  - With pc_reg=A in cycle N and no stall, inst_out/pc_out = ROM[A]/A in cycle N+1.
//  Next-PC priority, evaluated at each edge in RUN:
//  1. flush: pc_reg<=exc_pc; inst_valid<=0; inst_out<=0. Overrides stall and branch.
//  2. stall: pc_reg, pc_out, inst_out, inst_valid, fetch_count all held. branch_flag is ignored; ID keeps it asserted until released.
//  3. branch_flag: pc_reg<=branch_target. The word fetched this cycle is the delay slot and is captured with inst_valid=1.
//  4. otherwise: pc_reg<=pc_reg+4, wrapping from 32'hFFFF_FFFC to 0.
//  fetch_count:
//  - Increments on every RUN edge that captures with inst_valid<=1.
//  - No increment on flush, stall or BOOT.
//  - flush and stall in the same cycle: flush wins.
//  - rom_addr[1:0] is passed through unaltered; alignment is the ROM's concern unless the checking option below is compiled in.
// CONFIGURATION
//  Macro FETCH_ADDR_CHECK_EN.
//  Defined: adds output ports
//   fetch_exc  out 1   PC misaligned
//   bad_vaddr  out 32  offending PC
//  - When pc_reg[1:0]!=0 in RUN without stall, rom_en=0 for that cycle.
//  - The capture loads inst_out=0, inst_valid=0, fetch_exc=1, bad_vaddr=pc_reg.
//  - Both fetch_exc and bad_vaddr hold until the next flush or rst, which clear them to 0.
//  - PC still advances by the normal priority until flush arrives.
//  Undefined: the ports do not exist and there is no alignment check.
// STRUCTURE
//  - Bus widths come from the shared bus.v header: ADDR_BUS, DATA_BUS, MEM_SEL_BUS.
//  - Add to that header: INST_NOP (32'h0) and the FSM state encodings FETCH_BOOT=1'b0 and FETCH_RUN=1'b1.
//  - One sub-module, inst_fetch_pc: pc_reg plus the next-PC priority mux.
//  - The IF/ID register, FSM and counter stay in inst_fetch.
// TESTING (bench uses a behavioural ROM model, mem[a]=a)
//  1. Release rst at cycle 0 -> cycle 1 rom_en=0 (BOOT); cycle 2 rom_addr=BFC00000;
//     cycle 3 inst_out=BFC00000, inst_valid=1, fetch_count=1.
//  2. Free run 4 cycles -> pc_out sequence BFC00000, 04, 08, 0C; fetch_count=4.
//  3. stall high for 3 cycles at pc_reg=BFC00010 -> pc_out/inst_out/fetch_count frozen, rom_en=0;
//     on release the next capture is BFC00010.
//  4. branch_flag=1, target=BFC00100, while fetching BFC00014 -> captures BFC00014 (delay slot), then BFC00100.
//  5. flush=1 with stall=1 and branch_flag=1, exc_pc=BFC00380 -> next cycle inst_valid=0, count unchanged;
//     the following capture is BFC00380.
//  6. [FETCH_ADDR_CHECK_EN] branch to BFC00102 -> fetch_exc=1, bad_vaddr=BFC00102, inst_valid=0;
//     cleared by flush.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared bus widths, NOP encoding, fetch FSM states and next-PC select helper for inst_fetch.
package inst_fetch_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [DATA_BUS-1:0] INST_NOP = 32'h0000_0000;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_SEQ,
        NPC_BRANCH,
        NPC_FLUSH
    } npc_sel_e;

    // Flush beats stall beats branch; nothing moves outside RUN.
    function automatic npc_sel_e npc_select(input logic run, input logic stall,
                                            input logic flush, input logic branch_flag);
        if (!run)             return NPC_HOLD;
        else if (flush)       return NPC_FLUSH;
        else if (stall)       return NPC_HOLD;
        else if (branch_flag) return NPC_BRANCH;
        else                  return NPC_SEQ;
    endfunction

endpackage

// File: rtl/inst_fetch_pc.sv
// Program counter register and next-PC priority mux for inst_fetch.
module inst_fetch_pc
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_BUS-1:0] exc_pc,
    input  logic                branch_flag,
    input  logic [ADDR_BUS-1:0] branch_target,
    output logic [ADDR_BUS-1:0] pc_reg
);

    npc_sel_e            sel;
    logic [ADDR_BUS-1:0] pc_next;

    always_comb begin
        sel     = npc_select(run, stall, flush, branch_flag);
        pc_next = pc_reg;
        case (sel)
            NPC_FLUSH:  pc_next = exc_pc;
            NPC_BRANCH: pc_next = branch_target;
            NPC_SEQ:    pc_next = pc_reg + 32'd4;  // wraps naturally at 2^32
            default:    pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) pc_reg <= RESET_PC;
        else     pc_reg <= pc_next;
    end

endmodule

// File: rtl/inst_fetch.sv
// TinyMIPS instruction-fetch initiator: drives the ROM bus and registers {pc, inst} into IF/ID.
// Optional macro FETCH_ADDR_CHECK_EN adds misaligned-PC detection (fetch_exc/bad_vaddr ports).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC  = 32'hBFC0_0000,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [ADDR_BUS-1:0]    exc_pc,
    input  logic                   branch_flag,
    input  logic [ADDR_BUS-1:0]    branch_target,
    output logic                   rom_en,
    output logic [MEM_SEL_BUS-1:0] rom_write_en,
    output logic [ADDR_BUS-1:0]    rom_addr,
    output logic [DATA_BUS-1:0]    rom_write_data,
    input  logic [DATA_BUS-1:0]    rom_read_data,
    output logic [ADDR_BUS-1:0]    pc_out,
    output logic [DATA_BUS-1:0]    inst_out,
    output logic                   inst_valid,
`ifdef FETCH_ADDR_CHECK_EN
    output logic                   fetch_exc,
    output logic [ADDR_BUS-1:0]    bad_vaddr,
`endif
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    fetch_state_e        state;
    logic [ADDR_BUS-1:0] pc_reg;
    logic                run;
    logic                addr_fault;

    assign run = (state == FETCH_RUN);

`ifdef FETCH_ADDR_CHECK_EN
    assign addr_fault = (pc_reg[1:0] != 2'b00);
`else
    assign addr_fault = 1'b0;
`endif

    assign rom_en         = run && !stall && !addr_fault;
    assign rom_addr       = pc_reg;
    assign rom_write_en   = '0;
    assign rom_write_data = '0;

    inst_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .stall         (stall),
        .flush         (flush),
        .exc_pc        (exc_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc_reg        (pc_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_BOOT;
            pc_out      <= '0;
            inst_out    <= INST_NOP;
            inst_valid  <= 1'b0;
            fetch_count <= '0;
`ifdef FETCH_ADDR_CHECK_EN
            fetch_exc   <= 1'b0;
            bad_vaddr   <= '0;
`endif
        end else begin
            case (state)
                FETCH_BOOT: state <= FETCH_RUN;
                FETCH_RUN: begin
                    if (flush) begin
                        pc_out     <= pc_reg;
                        inst_out   <= INST_NOP;
                        inst_valid <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
                        fetch_exc  <= 1'b0;
                        bad_vaddr  <= '0;
`endif
                    end else if (!stall) begin
                        pc_out <= pc_reg;
                        if (addr_fault) begin
                            inst_out   <= INST_NOP;
                            inst_valid <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
                            // First offending PC is kept until a flush clears it.
                            if (!fetch_exc) bad_vaddr <= pc_reg;
                            fetch_exc  <= 1'b1;
`endif
                        end else begin
                            inst_out    <= rom_read_data;
                            inst_valid  <= 1'b1;
                            fetch_count <= fetch_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= FETCH_BOOT;
            endcase
        end
    end

endmodule
